// File: rtl/ble_phy_pkg.sv
// Shared definitions for the BLE PHY CRC-16 generator (TX) and checker (RX).
package ble_phy_pkg;

    localparam int unsigned CRC16_LEN  = 16;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPayload = 2'd1,
        StAppend  = 2'd2
    } ble_crc_state_e;

    // UAP/DCI lands bit-reversed in the low byte of the CRC register.
    function automatic logic [15:0] crc16_seed(input logic [7:0] uap_dci);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s[i] = uap_dci[7-i];
        end
        return s;
    endfunction

endpackage

// File: rtl/crc16_lfsr_step_bluetooth.sv
// One-bit step of the CRC-16 (x^16+x^12+x^5+1) LFSR; shared by TX and RX.
module crc16_lfsr_step_bluetooth
    import ble_phy_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic        data_i,
    output logic [15:0] crc_o
);

    logic fb;

    assign fb    = crc_i[15] ^ data_i;
    assign crc_o = {crc_i[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);

endmodule

// File: rtl/tx_payload_crc_appender_bluetooth.sv
// Bit-serial TX payload pass-through that appends the CRC-16 MSB first after the last bit.
module tx_payload_crc_appender_bluetooth
    import ble_phy_pkg::*;
#(
    parameter int unsigned CRC_LENGTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uap_dci,
    input  logic       clear_reg,
    input  logic       data_in,
    input  logic       valid_in,
    input  logic       last_in,
    output logic       data_out,
    output logic       valid_out,
    output logic       busy,
    output logic       crc_done,
    output logic       err_overrun
);

    ble_crc_state_e        state_q;
    logic [CRC_LENGTH-1:0] crc_q;
    logic [15:0]           crc_next;
    logic [3:0]            cnt_q;
    logic                  data_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    crc16_lfsr_step_bluetooth u_step (
        .crc_i  (crc_q),
        .data_i (data_in),
        .crc_o  (crc_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            crc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StPayload: begin
                    if (valid_in) begin
                        crc_q   <= crc_next;
                        data_q  <= data_in;
                        valid_q <= 1'b1;
                        if (last_in) begin
                            state_q <= StAppend;
                            cnt_q   <= 4'd15;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= StPayload;
                        end
                    end else begin
                        valid_q <= 1'b0;
                        // Reseeding is only allowed between packets.
                        if (state_q == StIdle && clear_reg) begin
                            crc_q <= crc16_seed(uap_dci);
                            err_q <= 1'b0;
                        end
                    end
                end
                StAppend: begin
                    data_q  <= crc_q[15];
                    valid_q <= 1'b1;
                    crc_q   <= {crc_q[CRC_LENGTH-2:0], 1'b0};
                    cnt_q   <= cnt_q - 4'd1;
                    if (valid_in) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q == 4'd0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign busy        = busy_q;
    assign crc_done    = done_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_tx_payload_crc_appender_bluetooth.sv
// Scoreboard bench: driver queues expected bits from a CRC model, monitor compares DUT output.
module tb_tx_payload_crc_appender_bluetooth;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] uap_dci = 8'h00;
    logic       clear_reg = 1'b0;
    logic       data_in = 1'b0;
    logic       valid_in = 1'b0;
    logic       last_in = 1'b0;
    logic       data_out, valid_out, busy, crc_done, err_overrun;

    always #5 clk = ~clk;

    tx_payload_crc_appender_bluetooth #(.CRC_LENGTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .uap_dci     (uap_dci),
        .clear_reg   (clear_reg),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .last_in     (last_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .busy        (busy),
        .crc_done    (crc_done),
        .err_overrun (err_overrun)
    );

    typedef struct packed {
        logic d;
        logic done;
        logic is_crc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    bit          pay_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          n_ones = 0;
    int          n_busy = 0;
    int          crc_idx = 0;
    int          pkt_done = 0;
    logic [15:0] rx_crc = 16'h0;
    logic [15:0] got_crc = 16'h0;

    // Reference: message polynomial division with the seed preloaded into the remainder.
    function automatic logic [15:0] seed_of(input logic [7:0] s);
        logic [15:0] r;
        r = 16'h0;
        for (int i = 0; i < 8; i++) r[i] = s[7-i];
        return r;
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic [15:0] sh;
        sh = c << 1;
        return (c[15] ^ b) ? (sh ^ 16'h1021) : sh;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data_out", {31'd0, data_out}, {31'd0, e.d});
                check("crc_done", {31'd0, crc_done}, {31'd0, e.done});
                n_out++;
                if (data_out) n_ones++;
                rx_crc  = crc_step(rx_crc, data_out);
                got_crc = {got_crc[14:0], data_out};
                if (e.is_crc) crc_idx++;
                if (e.done) begin
                    check("rx_remainder", {16'd0, rx_crc}, 32'd0);
                    pkt_done++;
                end
            end
        end else if (crc_done) begin
            check("crc_done_without_valid", 32'd1, 32'd0);
        end
        if (busy) n_busy++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input logic [7:0] seed);
        uap_dci   = seed;
        clear_reg = 1'b1;
        tick();
        clear_reg = 1'b0;
    endtask

    // Sends pay_q as one packet. abort_at > 0 drops reset after that many CRC bits.
    task automatic send_pkt(input logic [7:0] seed, input int gap_max, input bit ov,
                            input int abort_at);
        logic [15:0] c;
        int          start;
        int          waited;
        int          len;
        len = pay_q.size();
        do_clear(seed);
        rx_crc  = seed_of(seed);
        n_out   = 0;
        n_ones  = 0;
        n_busy  = 0;
        crc_idx = 0;
        c = seed_of(seed);
        foreach (pay_q[i]) begin
            c = crc_step(c, pay_q[i]);
            exp_q.push_back('{pay_q[i], 1'b0, 1'b0});
        end
        for (int i = 15; i >= 0; i--) exp_q.push_back('{c[i], (i == 0), 1'b1});
        start = pkt_done;
        for (int i = 0; i < len; i++) begin
            valid_in = 1'b1;
            data_in  = pay_q[i];
            last_in  = (i == len - 1);
            tick();
            valid_in = 1'b0;
            last_in  = 1'b0;
            if (gap_max > 0 && i != len - 1) begin
                repeat ($urandom_range(gap_max, 0)) tick();
            end
        end
        if (ov) begin
            repeat (3) begin
                valid_in = 1'b1;
                data_in  = 1'($urandom);
                tick();
            end
            valid_in = 1'b0;
        end
        if (abort_at > 0) begin
            waited = 0;
            while (crc_idx < abort_at && waited < 100) begin
                @(negedge clk);
                #1;
                waited++;
            end
            check("abort_wait_timeout", {31'd0, (crc_idx >= abort_at)}, 32'd1);
            reset = 1'b0;
            #1;
            check("rst_data_out", {31'd0, data_out}, 32'd0);
            check("rst_valid_out", {31'd0, valid_out}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_crc_done", {31'd0, crc_done}, 32'd0);
            check("rst_err_overrun", {31'd0, err_overrun}, 32'd0);
            exp_q.delete();
            repeat (4) tick();
            reset = 1'b1;
            tick();
            return;
        end
        waited = 0;
        while (pkt_done == start && waited < 100) begin
            tick();
            waited++;
        end
        check("packet_completed", {31'd0, (pkt_done != start)}, 32'd1);
        check("valid_out_after_done", {31'd0, valid_out}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("busy_cycles", n_busy, 32'd16);
        check("output_bit_count", n_out, len + 16);
        check("err_overrun", {31'd0, err_overrun}, {31'd0, ov});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", {31'd0, data_out}, 32'd0);
        check("reset_valid_out", {31'd0, valid_out}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_crc_done", {31'd0, crc_done}, 32'd0);
        check("reset_err_overrun", {31'd0, err_overrun}, 32'd0);
        reset = 1'b1;
        tick();

        // Impulse: single '1' from a zero seed gives the generator polynomial.
        pay_q = '{1'b1};
        send_pkt(8'h00, 0, 1'b0, 0);
        check("impulse_crc", {16'd0, got_crc}, 32'h1021);

        // Seed only: 0x80 reverses into bit 0, one zero bit shifts it to bit 1.
        pay_q = '{1'b0};
        send_pkt(8'h80, 0, 1'b0, 0);
        check("seed_only_crc", {16'd0, got_crc}, 32'h0002);

        // Zero packet: eight zero bits from a zero seed leave everything zero.
        pay_q.delete();
        repeat (8) pay_q.push_back(1'b0);
        send_pkt(8'h00, 0, 1'b0, 0);
        check("zero_pkt_ones", n_ones, 32'd0);

        // Overrun during APPEND: stream unchanged, flag sticky until clear.
        pay_q.delete();
        repeat (12) pay_q.push_back(1'($urandom));
        send_pkt(8'($urandom), 2, 1'b1, 0);
        do_clear(8'h00);
        check("err_cleared", {31'd0, err_overrun}, 32'd0);

        // Abort mid-APPEND, then a fresh packet must still be correct.
        pay_q.delete();
        repeat (20) pay_q.push_back(1'($urandom));
        send_pkt(8'($urandom), 1, 1'b0, 5);
        pay_q.delete();
        repeat (20) pay_q.push_back(1'($urandom));
        send_pkt(8'($urandom), 1, 1'b0, 0);

        // Randomized loopback packets.
        for (int p = 0; p < 20; p++) begin
            pay_q.delete();
            repeat ($urandom_range(255, 1)) pay_q.push_back(1'($urandom));
            send_pkt(8'($urandom), 3, 1'b0, 0);
        end

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
